// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the ALU opcode encoding used by
// decode, the ID/EX stage and the execute-stage ALU.
package cpu_pkg;

  localparam int unsigned CpuXlen  = 32;
  localparam int unsigned CpuRegAw = 5;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSll  = 4'b0011,
    AluMul  = 4'b0100,
    AluMulh = 4'b0101,
    AluSub  = 4'b0110,
    AluXor  = 4'b1000,
    AluSrl  = 4'b1010,
    AluSra  = 4'b1011
  } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one register source: MEM beats WB, x0 never forwards.
// Forwarding is only built when ID_EX_FWD_EN is defined; otherwise the register-file value passes.
module fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   value
);

`ifdef ID_EX_FWD_EN
  logic rs_nonzero;
  logic mem_hit;
  logic wb_hit;

  assign rs_nonzero = (rs != '0);
  assign mem_hit    = mem_we && (mem_rd == rs) && rs_nonzero;
  assign wb_hit     = wb_we && (wb_rd == rs) && rs_nonzero;

  always_comb begin
    value = rs_data;
    if (mem_hit) begin
      value = mem_data;
    end else if (wb_hit) begin
      value = wb_data;
    end
  end
`else
  // Ports stay for a uniform interface; the hazard unit stalls on every RAW instead.
  logic unused_fwd;
  assign unused_fwd = ^{rs, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign value      = rs_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operands (optionally forwarded, ID_EX_FWD_EN),
// selects ALU sources and holds them for execute under valid/ready with flush.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = CpuXlen,
  parameter int unsigned REG_AW = CpuRegAw
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [3:0]        in_alu_ctrl,
  input  logic              in_a_sel_pc,
  input  logic              in_b_sel_imm,
  input  logic              in_reg_write,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            accept;

  logic              valid_d, valid_q;
  logic [XLEN-1:0]   a_d, a_q;
  logic [XLEN-1:0]   b_d, b_q;
  logic [XLEN-1:0]   store_d, store_q;
  logic [3:0]        ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic              rw_d, rw_q;

  fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .rs       (in_rs1),
    .rs_data  (in_rs1_data),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .value    (fwd_rs1)
  );

  fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .rs       (in_rs2),
    .rs_data  (in_rs2_data),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .value    (fwd_rs2)
  );

  // rst term keeps decode unblocked while the valid bit is being cleared.
  assign in_ready = rst || !valid_q || ex_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    store_d = store_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    rw_d    = rw_q;

    // Flush kills both the held entry and the same-cycle input.
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end

    // Payload only moves on accept; drain and flush leave it untouched.
    if (accept) begin
      a_d     = in_a_sel_pc ? in_pc : fwd_rs1;
      b_d     = in_b_sel_imm ? in_imm : fwd_rs2;
      store_d = fwd_rs2;
      ctrl_d  = in_alu_ctrl;
      rd_d    = in_rd;
      rw_d    = in_reg_write && (in_rd != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      store_q <= '0;
      ctrl_q  <= 4'b0000;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      store_q <= store_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_store_data = store_q;
  assign ex_alu_ctrl   = ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for capture/forwarding plus
// hand-written hold, drain, flush and reset sequences.
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_ctrl;
  logic        in_a_sel_pc, in_b_sel_imm, in_reg_write;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_alu_ctrl  (in_alu_ctrl),
    .in_a_sel_pc  (in_a_sel_pc),
    .in_b_sel_imm (in_b_sel_imm),
    .in_reg_write (in_reg_write),
    .mem_fwd_we   (mem_fwd_we),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_we    (wb_fwd_we),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        a_sel, b_sel, rw;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    // expected with forwarding built / without
    logic [31:0] ea_f, eb_f, es_f;
    logic [31:0] ea_n, eb_n, es_n;
    logic        erw;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_pc        = v.pc;
    in_rs1_data  = v.rs1_data;
    in_rs2_data  = v.rs2_data;
    in_imm       = v.imm;
    in_rs1       = v.rs1;
    in_rs2       = v.rs2;
    in_rd        = v.rd;
    in_alu_ctrl  = v.ctrl;
    in_a_sel_pc  = v.a_sel;
    in_b_sel_imm = v.b_sel;
    in_reg_write = v.rw;
    mem_fwd_we   = v.mwe;
    mem_fwd_rd   = v.mrd;
    mem_fwd_data = v.mdata;
    wb_fwd_we    = v.wwe;
    wb_fwd_rd    = v.wrd;
    wb_fwd_data  = v.wdata;
  endtask

  function automatic logic [31:0] exp_a(input vec_t v);
    return FwdEn ? v.ea_f : v.ea_n;
  endfunction

  function automatic logic [31:0] exp_b(input vec_t v);
    return FwdEn ? v.eb_f : v.eb_n;
  endfunction

  function automatic logic [31:0] exp_s(input vec_t v);
    return FwdEn ? v.es_f : v.es_n;
  endfunction

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, " ex_valid"}, {31'b0, ex_valid}, 32'd1);
    chk({tag, " ex_a"}, ex_a, exp_a(v));
    chk({tag, " ex_b"}, ex_b, exp_b(v));
    chk({tag, " ex_store_data"}, ex_store_data, exp_s(v));
    chk({tag, " ex_alu_ctrl"}, {28'b0, ex_alu_ctrl}, {28'b0, v.ctrl});
    chk({tag, " ex_rd"}, {27'b0, ex_rd}, {27'b0, v.rd});
    chk({tag, " ex_reg_write"}, {31'b0, ex_reg_write}, {31'b0, v.erw});
  endtask

  initial begin
    //           name      pc        rs1d      rs2d      imm         rs1 rs2 rd  ctrl   as bs rw
    //           mwe mrd mdata     wwe wrd wdata     ea_f eb_f es_f / ea_n eb_n es_n  erw
    vecs[0] = '{"basic", 32'h40, 32'h10, 32'h20, 32'h4, 5'd5, 5'd6, 5'd7, AluAdd, 0, 0, 1,
                0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'h10, 32'h20, 32'h20, 32'h10, 32'h20, 32'h20, 1};
    vecs[1] = '{"prio_mem", 32'h44, 32'h1111, 32'h2222, 32'h0, 5'd3, 5'd4, 5'd8, AluSub, 0, 0, 1,
                1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB,
                32'hAAAA, 32'h2222, 32'h2222, 32'h1111, 32'h2222, 32'h2222, 1};
    vecs[2] = '{"prio_wb", 32'h48, 32'h1111, 32'h2222, 32'h0, 5'd3, 5'd4, 5'd8, AluSub, 0, 0, 1,
                0, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB,
                32'hBBBB, 32'h2222, 32'h2222, 32'h1111, 32'h2222, 32'h2222, 1};
    vecs[3] = '{"x0", 32'h4C, 32'h0, 32'h99, 32'h0, 5'd0, 5'd9, 5'd0, AluXor, 0, 0, 1,
                1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF,
                32'h0, 32'h99, 32'h99, 32'h0, 32'h99, 32'h99, 0};
    vecs[4] = '{"srcsel", 32'h100, 32'h5, 32'h77, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd10, AluAdd, 1, 1, 1,
                1, 5'd2, 32'hCAFE, 0, 5'd0, 32'h0,
                32'h100, 32'hFFFFFFFC, 32'hCAFE, 32'h100, 32'hFFFFFFFC, 32'h77, 1};
    vecs[5] = '{"split", 32'h50, 32'h1, 32'h2, 32'h0, 5'd11, 5'd12, 5'd13, AluOr, 0, 0, 0,
                1, 5'd11, 32'h1234, 1, 5'd12, 32'h5678,
                32'h1234, 32'h5678, 32'h5678, 32'h1, 32'h2, 32'h2, 0};
    vecs[6] = '{"both_same", 32'h54, 32'h3, 32'h4, 32'h0, 5'd12, 5'd12, 5'd31, AluSra, 0, 0, 1,
                1, 5'd12, 32'h9, 1, 5'd12, 32'h8,
                32'h9, 32'h9, 32'h9, 32'h3, 32'h4, 32'h4, 1};

    // Reset
    rst = 1'b1; in_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    drive(vecs[0]);
    #1;
    chk("in_ready during reset", {31'b0, in_ready}, 32'd1);
    step();
    step();
    chk("rst ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst ex_a", ex_a, 32'h0);
    chk("rst ex_b", ex_b, 32'h0);
    chk("rst ex_store_data", ex_store_data, 32'h0);
    chk("rst ex_alu_ctrl", {28'b0, ex_alu_ctrl}, 32'h0);
    chk("rst ex_rd", {27'b0, ex_rd}, 32'h0);
    chk("rst ex_reg_write", {31'b0, ex_reg_write}, 32'h0);
    rst = 1'b0;

    // Back-to-back table accepts
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      step();
      chk_out(vecs[i].name, vecs[i]);
    end

    // Back-pressure: hold vecs[6] while vecs[0] is presented and producers change
    ex_ready = 1'b0;
    drive(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd12; mem_fwd_data = 32'hF00D + c;
      step();
      chk_out("hold", vecs[6]);
    end
    drive(vecs[0]);
    ex_ready = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk_out("release", vecs[0]);

    // Drain: valid drops, payload stays
    in_valid = 1'b0;
    step();
    chk("drain ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("drain ex_a kept", ex_a, 32'h10);

    // Flush while valid with a valid input present
    in_valid = 1'b1;
    drive(vecs[1]);
    step();
    chk_out("pre_flush", vecs[1]);
    drive(vecs[0]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush ex_a kept", ex_a, exp_a(vecs[1]));
    step();
    chk_out("post_flush", vecs[0]);

    // Reset during hold discards the held instruction
    drive(vecs[5]);
    step();
    chk_out("pre_rst_hold", vecs[5]);
    ex_ready = 1'b0;
    drive(vecs[6]);
    step();
    chk_out("rst_hold", vecs[5]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midhold rst ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("midhold rst ex_a", ex_a, 32'h0);
    chk("midhold rst in_ready", {31'b0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
